// File: rtl/tty_pkg.sv
// Shared types and constants for the glass-TTY character writer.
package tty_pkg;

  localparam int unsigned DEF_COLS = 128;
  localparam int unsigned DEF_ROWS = 32;
  localparam int unsigned MEM_AW   = 11;
  localparam int unsigned MEM_DW   = 64;

  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_TAB   = 8'h09;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] PRINT_LO   = 8'h20;
  localparam logic [7:0] PRINT_HI   = 8'h7E;

  localparam logic [MEM_DW-1:0] WORD_SPACES = {8{CHAR_SPACE}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SCROLL_RD,
    ST_SCROLL_WR,
    ST_SCROLL_CLR,
    ST_CLEAR
  } tty_state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/tty_char_writer_if.sv
// Byte stream, character RAM port b and cursor status of the TTY writer.
interface tty_char_writer_if import tty_pkg::*; #(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS
);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);

  logic [7:0]        char_i;
  logic              char_valid_i;
  logic              char_ready_o;
  logic              mem_en_o;
  logic [7:0]        mem_we_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [MEM_DW-1:0] mem_wdata_o;
  logic [MEM_DW-1:0] mem_rdata_i;
  logic [CW-1:0]     cursor_col_o;
  logic [RW-1:0]     cursor_row_o;
  logic              busy_o;

  // Byte source / RAM side
  modport master (
    output char_i, char_valid_i, mem_rdata_i,
    input  char_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
           cursor_col_o, cursor_row_o, busy_o
  );

  // Writer side
  modport slave (
    input  char_i, char_valid_i, mem_rdata_i,
    output char_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
           cursor_col_o, cursor_row_o, busy_o
  );
endinterface

// File: rtl/tty_block_sequencer.sv
// Word-index walker for block copies and fills; optional read-then-write per word.
module tty_block_sequencer import tty_pkg::*; #(
  parameter int unsigned RESET_LEN    = 512,
  parameter int unsigned RD_OFFSET    = 16,
  parameter bit          START_ACTIVE = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start,
  input  logic [MEM_AW-1:0] base,
  input  logic [MEM_AW-1:0] len,
  input  logic              rw_mode,
  output logic [MEM_AW-1:0] addr_c,
  output logic              done_c
);

  logic              active_q;
  logic              rd_phase_q;
  logic              rw_mode_q;
  logic [MEM_AW-1:0] base_q;
  logic [MEM_AW-1:0] len_q;
  logic [MEM_AW-1:0] cnt_q;

  // Read phase fetches the source word RD_OFFSET ahead of the destination
  assign addr_c = base_q + cnt_q + (rd_phase_q ? MEM_AW'(RD_OFFSET) : '0);
  assign done_c = active_q && !rd_phase_q && (cnt_q == len_q - MEM_AW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q   <= START_ACTIVE;
      rd_phase_q <= 1'b0;
      rw_mode_q  <= 1'b0;
      base_q     <= '0;
      len_q      <= MEM_AW'(RESET_LEN);
      cnt_q      <= '0;
    end else if (start) begin
      active_q   <= 1'b1;
      rd_phase_q <= rw_mode;
      rw_mode_q  <= rw_mode;
      base_q     <= base;
      len_q      <= len;
      cnt_q      <= '0;
    end else if (active_q) begin
      if (rd_phase_q) begin
        rd_phase_q <= 1'b0;
      end else if (done_c) begin
        active_q <= 1'b0;
      end else begin
        cnt_q      <= cnt_q + MEM_AW'(1);
        rd_phase_q <= rw_mode_q;
      end
    end
  end

endmodule

// File: rtl/tty_char_writer.sv
// Glass-TTY front end: decodes a byte stream into character RAM writes,
// cursor motion, scroll-up and full-screen clear.
module tty_char_writer import tty_pkg::*; #(
  parameter int unsigned COLS           = DEF_COLS,
  parameter int unsigned ROWS           = DEF_ROWS,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic               clk_i,
  input logic               rst_ni,
  tty_char_writer_if.slave  bus
);

  localparam int unsigned CW        = $clog2(COLS);
  localparam int unsigned RW        = $clog2(ROWS);
  localparam int unsigned WB        = CW - 3;
  localparam int unsigned W         = COLS / 8;
  localparam int unsigned TOTAL     = ROWS * W;
  localparam int unsigned COPY_LEN  = (ROWS - 1) * W;
  localparam int unsigned LAST_BASE = (ROWS - 1) * W;

  tty_state_e        state_q;
  logic [7:0]        ch_q;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic              ready_q;
  logic              busy_q;
  logic              mem_en_q;
  logic [7:0]        mem_we_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [MEM_DW-1:0] wdata_q;
  logic              copy_q;

  logic              printable_c;
  logic              adv_c;
  logic              scroll_c;
  logic [CW-1:0]     col_nx_c;

  logic              seq_start_c;
  logic [MEM_AW-1:0] seq_base_c;
  logic [MEM_AW-1:0] seq_len_c;
  logic              seq_rw_c;
  logic [MEM_AW-1:0] seq_addr_c;
  logic              seq_done_c;

  // Cursor motion for the latched byte
  always_comb begin
    col_nx_c    = col_q;
    adv_c       = 1'b0;
    printable_c = is_printable(ch_q);
    if (printable_c) begin
      if (col_q == CW'(COLS - 1)) begin
        col_nx_c = '0;
        adv_c    = 1'b1;
      end else begin
        col_nx_c = col_q + CW'(1);
      end
    end else begin
      case (ch_q)
        CHAR_CR:  col_nx_c = '0;
        CHAR_LF:  adv_c = 1'b1;
        CHAR_BS:  if (col_q != '0) col_nx_c = col_q - CW'(1);
        CHAR_TAB: begin
          col_nx_c = {col_q[CW-1:3] + WB'(1), 3'b000};
          adv_c    = &col_q[CW-1:3];
        end
        CHAR_FF:  col_nx_c = '0;
        default:  ;
      endcase
    end
    scroll_c = adv_c && (row_q == RW'(ROWS - 1));
  end

  // Block-operation launches: full clear, scroll copy, then last-row fill
  always_comb begin
    seq_start_c = 1'b0;
    seq_base_c  = '0;
    seq_len_c   = MEM_AW'(TOTAL);
    seq_rw_c    = 1'b0;
    if (state_q == ST_EXEC) begin
      if (ch_q == CHAR_FF) begin
        seq_start_c = 1'b1;
      end else if (scroll_c) begin
        seq_start_c = 1'b1;
        seq_len_c   = MEM_AW'(COPY_LEN);
        seq_rw_c    = 1'b1;
      end
    end else if (state_q == ST_SCROLL_WR && seq_done_c) begin
      seq_start_c = 1'b1;
      seq_base_c  = MEM_AW'(LAST_BASE);
      seq_len_c   = MEM_AW'(W);
    end
  end

  tty_block_sequencer #(
    .RESET_LEN    (TOTAL),
    .RD_OFFSET    (W),
    .START_ACTIVE (CLEAR_ON_RESET)
  ) u_seq (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start   (seq_start_c),
    .base    (seq_base_c),
    .len     (seq_len_c),
    .rw_mode (seq_rw_c),
    .addr_c  (seq_addr_c),
    .done_c  (seq_done_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      ready_q    <= ~CLEAR_ON_RESET;
      busy_q     <= CLEAR_ON_RESET;
      ch_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= '0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      copy_q     <= 1'b0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= '0;
      copy_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.char_valid_i) begin
            ch_q    <= bus.char_i;
            ready_q <= 1'b0;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          col_q <= col_nx_c;
          if (printable_c) begin
            mem_en_q   <= 1'b1;
            mem_we_q   <= 8'b1 << col_q[2:0];
            mem_addr_q <= MEM_AW'({row_q, col_q[CW-1:3]});
            wdata_q    <= {8{ch_q}};
          end
          if (ch_q == CHAR_FF) begin
            row_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_CLEAR;
          end else if (scroll_c) begin
            busy_q  <= 1'b1;
            state_q <= ST_SCROLL_RD;
          end else begin
            if (adv_c) row_q <= row_q + RW'(1);
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_SCROLL_RD: begin
          mem_en_q   <= 1'b1;
          mem_addr_q <= seq_addr_c;
          state_q    <= ST_SCROLL_WR;
        end
        ST_SCROLL_WR: begin
          // Write data is forwarded straight from the read port next cycle
          mem_en_q   <= 1'b1;
          mem_we_q   <= 8'hFF;
          mem_addr_q <= seq_addr_c;
          copy_q     <= 1'b1;
          state_q    <= seq_done_c ? ST_SCROLL_CLR : ST_SCROLL_RD;
        end
        ST_SCROLL_CLR, ST_CLEAR: begin
          mem_en_q   <= 1'b1;
          mem_we_q   <= 8'hFF;
          mem_addr_q <= seq_addr_c;
          wdata_q    <= WORD_SPACES;
          if (seq_done_c) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.char_ready_o = ready_q;
  assign bus.busy_o       = busy_q;
  assign bus.mem_en_o     = mem_en_q;
  assign bus.mem_we_o     = mem_we_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wdata_o  = copy_q ? bus.mem_rdata_i : wdata_q;
  assign bus.cursor_col_o = col_q;
  assign bus.cursor_row_o = row_q;

endmodule
